// File: rtl/l2c_miss_ctrl.sv
// l2c_miss_ctrl
// L2 miss/refill controller shared by NUM_CH L1 requesters. L2 hits are
// answered with a one-cycle update pulse straight from IDLE. Misses walk
// through the L1 replace handshake, an optional dirty writeback, an optional
// write-buffer hazard wait and finally the memory refill.
//
// Handshake semantics used on every request/response pair of this block:
//   - ch_replace_req, mem_dirty_req and mem_replace_req are levels that stay
//     high for as long as the FSM sits in the owning state.
//   - ch_ack qualifies ch_replace_req; mem_dirty_done and mem_replace_done
//     are single-cycle pulses that qualify their request. A response seen
//     while its request is low is ignored. The transfer completes on the
//     rising clock edge where request and response are both high.
//   - ch_req is a level held by the L1 until it sees ch_update_ena; a channel
//     is never granted in the cycle its own update pulse is high.
module l2c_miss_ctrl #(
    parameter int                NUM_CH        = 2,
    parameter logic [NUM_CH-1:0] WB_CHECK_MASK = 2'b10,
    parameter int                ACK_TIMEOUT   = 64,
    localparam int               CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_l2,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_miss,
    input  logic [NUM_CH-1:0] ch_dirty,
    input  logic [NUM_CH-1:0] ch_ack,
    input  logic              wb_read_tag_hit,
    input  logic              mem_dirty_done,
    input  logic              mem_replace_done,
    output logic [NUM_CH-1:0] ch_update_ena,
    output logic [NUM_CH-1:0] ch_replace_req,
    output logic              mem_dirty_req,
    output logic              mem_replace_req,
    output logic              data_addr_sel,
    output logic [CW-1:0]     mem_ch_sel,
    output logic              busy,
    output logic              ack_timeout_err,
    output logic [2:0]        dbg_state
);

    // Wider by one bit so the rotating scan can add an offset before wrapping.
    localparam int CW1 = CW + 1;

    // The ACK counter only has to reach ACK_TIMEOUT-1.
    localparam int            TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);
    localparam logic          TO_EN   = (ACK_TIMEOUT > 0);

    // FSM encoding.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_ACK  = 3'd1;
    localparam logic [2:0] S_REPLACE   = 3'd2;
    localparam logic [2:0] S_M_DIRTY   = 3'd3;
    localparam logic [2:0] S_WAIT_WB   = 3'd4;
    localparam logic [2:0] S_M_REPLACE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     gnt_q, gnt_d;       // channel owning the current miss
    logic [CW-1:0]     ptr_q, ptr_d;       // round-robin start index
    logic [TW-1:0]     cnt_q, cnt_d;       // cycles spent in WAIT_ACK
    logic              err_q, err_d;       // sticky ACK timeout flag
    logic [NUM_CH-1:0] upd_q, upd_d;       // registered update pulse

    logic [NUM_CH-1:0] eligible;
    logic              arb_found;
    logic [CW-1:0]     arb_idx;
    logic [CW1-1:0]    cand_sum;
    logic [NUM_CH-1:0] arb_oh;
    logic [NUM_CH-1:0] gnt_oh;
    logic              ack_hit;
    logic              wb_hold;

    // A channel whose update pulse is high this cycle has just been served.
    assign eligible = ch_req & ~upd_q;

    // Round-robin scan: first eligible channel at or above ptr_q, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_sum = {1'b0, ptr_q} + CW1'(i);
            if (cand_sum >= CW1'(NUM_CH)) begin
                cand_sum = cand_sum - CW1'(NUM_CH);
            end
            if (!arb_found && eligible[cand_sum[CW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_sum[CW-1:0];
            end
        end
    end

    // One-hot decodes of the scan result and of the latched grant.
    always_comb begin
        arb_oh = '0;
        gnt_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_oh[i] = (arb_idx == CW'(i));
            gnt_oh[i] = (gnt_q == CW'(i));
        end
    end

    // Only the owning channel's acknowledge counts.
    assign ack_hit = |(ch_ack & gnt_oh);

    // Refill must wait while the write buffer still holds this address.
    assign wb_hold = WB_CHECK_MASK[gnt_q] & wb_read_tag_hit;

    // Next-state logic for the miss sequence and the IDLE hit path.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        upd_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    ptr_d = (arb_idx == CW'(NUM_CH - 1)) ? '0 : (arb_idx + 1'b1);
                    if (ch_miss[arb_idx]) begin
                        // mem_ch_sel only follows misses, so it holds in IDLE.
                        gnt_d   = arb_idx;
                        cnt_d   = '0;
                        state_d = S_WAIT_ACK;
                    end else begin
                        upd_d = arb_oh;
                    end
                end
            end
            S_WAIT_ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (ack_hit) begin
                    state_d = S_REPLACE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    // Give up on the L1 and carry on; the flag records it.
                    err_d   = 1'b1;
                    state_d = S_REPLACE;
                end
            end
            S_REPLACE: begin
                if (ch_dirty[gnt_q]) begin
                    state_d = S_M_DIRTY;
                end else if (wb_hold) begin
                    state_d = S_WAIT_WB;
                end else begin
                    state_d = S_M_REPLACE;
                end
            end
            S_M_DIRTY: begin
                if (mem_dirty_done) begin
                    state_d = wb_hold ? S_WAIT_WB : S_M_REPLACE;
                end
            end
            S_WAIT_WB: begin
                if (!wb_read_tag_hit) begin
                    state_d = S_M_REPLACE;
                end
            end
            S_M_REPLACE: begin
                if (mem_replace_done) begin
                    state_d = S_IDLE;
                    upd_d   = gnt_oh;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction without a pulse.
    always_ff @(posedge clk_l2) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    // Outputs decode only registered state and the grant register.
    assign ch_update_ena   = upd_q;
    assign ch_replace_req  = (state_q == S_WAIT_ACK) ? gnt_oh : '0;
    assign mem_dirty_req   = (state_q == S_M_DIRTY);
    assign data_addr_sel   = (state_q == S_M_DIRTY);
    assign mem_replace_req = (state_q == S_M_REPLACE);
    assign mem_ch_sel      = gnt_q;
    assign busy            = (state_q != S_IDLE);
    assign ack_timeout_err = err_q;
    assign dbg_state       = state_q;

endmodule
